// File: rtl/block_led_shift.sv
// block_led_shift: board-level LED chaser on the 50 MHz system clock.
// A prescaler divides clk_50M down to a shift tick every SHIFT_DIV edges; an
// 8-bit one-hot pattern advances one position per tick and drives the LEDs
// straight from a register.
// Optional build macro: LEDSHIFT_BOUNCE_EN selects ping-pong (bounce) mode;
// without it the pattern rotates left.
module block_led_shift #(
    parameter int unsigned SHIFT_DIV = 12_500_000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic       clk_50M,
    input  logic       reset,
    output logic [7:0] out
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    dir_t             dir;

    assign tick = (cnt == CNT_LAST);

    // Prescaler: counts 0..SHIFT_DIV-1 and wraps on the tick edge.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // LED pattern and direction: advance once per tick, recover to 0x01/left
    // whenever the pattern has lost its one-hot property.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            out <= 8'h01;
            dir <= DIR_LEFT;
        end else if (tick) begin
            if (!$onehot(out)) begin
                out <= 8'h01;
                dir <= DIR_LEFT;
`ifdef LEDSHIFT_BOUNCE_EN
            // Direction flips on the same tick that lands on an end LED, so
            // each end is lit for exactly one tick.
            end else if (dir == DIR_LEFT) begin
                out <= {out[6:0], 1'b0};
                if (out[6]) begin
                    dir <= DIR_RIGHT;
                end
            end else begin
                out <= {1'b0, out[7:1]};
                if (out[1]) begin
                    dir <= DIR_LEFT;
                end
            end
`else
            // Rotate mode only ever moves left; a direction register that is
            // not "left" is treated like a corrupted pattern.
            end else if (dir != DIR_LEFT) begin
                out <= 8'h01;
                dir <= DIR_LEFT;
            end else begin
                out <= {out[6:0], out[7]};
            end
`endif
        end
    end

endmodule

// File: tb/tb_block_led_shift.sv
// tb_block_led_shift: self-checking bench for block_led_shift.
// Two instances share clock and reset: one with SHIFT_DIV=4, one with
// SHIFT_DIV=1. Expected LED values come from a tick-count model of the
// pattern sequence. Define LEDSHIFT_BOUNCE_EN for both RTL and bench to check
// the ping-pong build.
module tb_block_led_shift;

    logic       clk;
    logic       reset;
    logic [7:0] out4;
    logic [7:0] out1;

    int unsigned tests  = 0;
    int unsigned fails  = 0;
    int unsigned edges  = 0;   // rising edges seen since last reset release

    block_led_shift #(.SHIFT_DIV(4), .CNT_W(3)) dut4 (
        .clk_50M (clk),
        .reset   (reset),
        .out     (out4)
    );

    block_led_shift #(.SHIFT_DIV(1), .CNT_W(1)) dut1 (
        .clk_50M (clk),
        .reset   (reset),
        .out     (out1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // LED value after n shift ticks, straight from the visible sequence.
    function automatic logic [7:0] pattern(input int unsigned n);
        int unsigned k;
        logic [7:0] one;
        one = 8'h01;
`ifdef LEDSHIFT_BOUNCE_EN
        k = n % 14;
        if (k < 8) return one << k;
        return one << (14 - k);
`else
        k = n % 8;
        return one << k;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h (edges=%0d)", name, act, exp, edges);
        end
    endtask

    // Advance one rising edge (sampled at the following falling edge) and
    // compare both instances against the model.
    task automatic step_check();
        @(negedge clk);
        edges++;
        check("div4_model", out4, pattern(edges / 4));
        check("div1_model", out1, pattern(edges));
    endtask

    // Assert reset between edges, confirm asynchronous effect, hold, release.
    task automatic mid_reset(input int unsigned offset, input int unsigned hold);
        #(offset);
        reset = 1'b0;
        #1;
        check("async_reset_div4", out4, 8'h01);
        check("async_reset_div1", out1, 8'h01);
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_reset_div4", out4, 8'h01);
            check("hold_reset_div1", out1, 8'h01);
        end
        reset = 1'b1;
        edges = 0;
    endtask

    typedef struct {
        int unsigned edge_no;
        logic [7:0]  exp4;
        logic [7:0]  exp1;
    } vec_t;

    vec_t vecs[8];

    initial begin
`ifdef LEDSHIFT_BOUNCE_EN
        vecs[0] = '{1,  8'h01, 8'h02};
        vecs[1] = '{3,  8'h01, 8'h08};
        vecs[2] = '{4,  8'h02, 8'h10};
        vecs[3] = '{8,  8'h04, 8'h40};
        vecs[4] = '{28, 8'h80, 8'h01};
        vecs[5] = '{32, 8'h40, 8'h10};
        vecs[6] = '{56, 8'h01, 8'h01};
        vecs[7] = '{60, 8'h02, 8'h10};
`else
        vecs[0] = '{1,  8'h01, 8'h02};
        vecs[1] = '{3,  8'h01, 8'h08};
        vecs[2] = '{4,  8'h02, 8'h10};
        vecs[3] = '{8,  8'h04, 8'h01};
        vecs[4] = '{28, 8'h80, 8'h10};
        vecs[5] = '{32, 8'h01, 8'h01};
        vecs[6] = '{56, 8'h40, 8'h01};
        vecs[7] = '{60, 8'h80, 8'h10};
`endif

        // Reset held low for 100 cycles with the clock running.
        reset = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_hold_div4", out4, 8'h01);
            check("reset_hold_div1", out1, 8'h01);
        end

        // Release at a falling edge, then walk the table of fixed edge counts.
        reset = 1'b1;
        edges = 0;
        for (int unsigned v = 0; v < 8; v++) begin
            while (edges < vecs[v].edge_no - 1) step_check();
            @(negedge clk);
            edges++;
            check("vec_div4", out4, vecs[v].exp4);
            check("vec_div1", out1, vecs[v].exp1);
        end

        // Mid-interval reset while the divided instance shows 0x08.
        mid_reset(3, 2);
        while (edges < 13) step_check();
        check("pre_reset_0x08", out4, 8'h08);
        mid_reset(5, 3);
        for (int unsigned i = 1; i <= 3; i++) begin
            @(negedge clk);
            edges++;
            check("post_release_hold", out4, 8'h01);
        end
        @(negedge clk);
        edges++;
        check("post_release_shift", out4, 8'h02);

        // Randomized run lengths and reset placement against the model.
        for (int unsigned r = 0; r < 40; r++) begin
            int unsigned run;
            run = $urandom_range(1, 70);
            for (int unsigned i = 0; i < run; i++) step_check();
            mid_reset($urandom_range(1, 8), $urandom_range(0, 4));
        end
        for (int unsigned i = 0; i < 64; i++) step_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
